// File: rtl/pubkey_walk_ctrl_if.sv
// rtl/pubkey_walk_ctrl_if.sv - start/adder/output bus of pubkey_walk_ctrl (abort present under PUBKEY_WALK_ABORT_EN)
interface pubkey_walk_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [255:0]     start_x;
    logic [255:0]     start_y;
    logic [CNT_W-1:0] start_count;
    logic             adder_reset;
    logic [255:0]     adder_x;
    logic [255:0]     adder_y;
    logic             adder_done;
    logic [255:0]     adder_res_x;
    logic [255:0]     adder_res_y;
    logic             out_valid;
    logic             out_ready;
    logic [255:0]     out_x;
    logic [255:0]     out_y;
    logic [CNT_W-1:0] out_idx;
    logic             out_last;
    logic             busy;
`ifdef PUBKEY_WALK_ABORT_EN
    logic             abort;
`endif

    // Controller side.
    modport master (
`ifdef PUBKEY_WALK_ABORT_EN
        input  abort,
`endif
        input  start_valid, start_x, start_y, start_count,
        output start_ready,
        output adder_reset, adder_x, adder_y,
        input  adder_done, adder_res_x, adder_res_y,
        output out_valid, out_x, out_y, out_idx, out_last,
        input  out_ready,
        output busy
    );

    // Environment side: requester, adder and consumer.
    modport slave (
`ifdef PUBKEY_WALK_ABORT_EN
        output abort,
`endif
        output start_valid, start_x, start_y, start_count,
        input  start_ready,
        input  adder_reset, adder_x, adder_y,
        output adder_done, adder_res_x, adder_res_y,
        input  out_valid, out_x, out_y, out_idx, out_last,
        output out_ready,
        input  busy
    );
endinterface

// File: rtl/pubkey_walk_ctrl.sv
// rtl/pubkey_walk_ctrl.sv - walks start+k*G through an external point adder into an output FIFO (optional abort: PUBKEY_WALK_ABORT_EN)
module pubkey_walk_ctrl #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    pubkey_walk_ctrl_if.master  bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_STALL, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic             adder_reset_q, adder_reset_d;
    logic [255:0]     ax_q, ax_d, ay_q, ay_d;
    logic [CNT_W-1:0] rem_q, rem_d, idx_q, idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [255:0]     fifo_x_q    [DEPTH];
    logic [255:0]     fifo_y_q    [DEPTH];
    logic [CNT_W-1:0] fifo_idx_q  [DEPTH];
    logic             fifo_last_q [DEPTH];

    logic push, pop, abort_hit, head_valid;

`ifdef PUBKEY_WALK_ABORT_EN
    assign abort_hit = bus.abort && (state_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Abort wins over both a result push and a consumer pop on the same edge.
    assign head_valid = (occ_q != '0);
    assign pop        = head_valid && bus.out_ready && !abort_hit;
    assign push       = (state_q == S_WAIT) && bus.adder_done && !abort_hit;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state, operand, counter and FIFO pointer computation.
    always_comb begin
        state_d  = state_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (bus.start_valid) begin
                    ax_d  = bus.start_x;
                    ay_d  = bus.start_y;
                    rem_d = bus.start_count;
                    idx_d = '0;
                    if (bus.start_count != '0) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.adder_done) begin
                    ax_d  = bus.adder_res_x;
                    ay_d  = bus.adder_res_y;
                    idx_d = idx_q + CNT_W'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1))       state_d = S_DRAIN;
                    else if (int'(occ_d) < DEPTH) state_d = S_LAUNCH;
                    else                          state_d = S_STALL;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_STALL:  if (int'(occ_d) < DEPTH) state_d = S_LAUNCH;
            S_DRAIN:  if (occ_q == '0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (abort_hit) begin
            state_d  = S_IDLE;
            rem_d    = '0;
            idx_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end

        // The adder only runs while waiting on it; every other state holds it in reset.
        adder_reset_d = (state_d != S_WAIT);
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            adder_reset_q <= 1'b1;
            ax_q          <= '0;
            ay_q          <= '0;
            rem_q         <= '0;
            idx_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            adder_reset_q <= adder_reset_d;
            ax_q          <= ax_d;
            ay_q          <= ay_d;
            rem_q         <= rem_d;
            idx_q         <= idx_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // FIFO storage; contents need no reset since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x_q[wr_ptr_q]    <= bus.adder_res_x;
            fifo_y_q[wr_ptr_q]    <= bus.adder_res_y;
            fifo_idx_q[wr_ptr_q]  <= idx_q + CNT_W'(1);
            fifo_last_q[wr_ptr_q] <= (rem_q == CNT_W'(1));
        end
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.adder_reset = adder_reset_q;
    assign bus.adder_x     = ax_q;
    assign bus.adder_y     = ay_q;
    assign bus.out_valid   = head_valid;
    assign bus.out_x       = head_valid ? fifo_x_q[rd_ptr_q]    : '0;
    assign bus.out_y       = head_valid ? fifo_y_q[rd_ptr_q]    : '0;
    assign bus.out_idx     = head_valid ? fifo_idx_q[rd_ptr_q]  : '0;
    assign bus.out_last    = head_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_pubkey_walk_ctrl.sv
// tb/tb_pubkey_walk_ctrl.sv - randomized self-checking bench for pubkey_walk_ctrl with a secp256k1 adder model
module tb_pubkey_walk_ctrl;
    localparam int DEPTH = 2;
    localparam int CNT_W = 32;
    localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [255:0] G3X = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam logic [255:0] G3Y = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
    localparam logic [255:0] G4X = 256'hE493DBF1C10D80F3581E4904930B1404CC6C13900EE0758474FA94ABE8C4CD13;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pubkey_walk_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pubkey_walk_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // secp256k1 field and point arithmetic (affine P + G, P != +-G).
    function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = {256'b0, a} * {256'b0, b};
        t = t % {256'b0, P};
        return t[255:0];
    endfunction
    function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= {1'b0, P}) t = t - {1'b0, P};
        return t[255:0];
    endfunction
    function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
        return fadd(a, P - b);
    endfunction
    function automatic logic [255:0] finv(input logic [255:0] a);
        logic [255:0] r, e;
        r = 256'd1;
        e = P - 256'd2;
        for (int i = 255; i >= 0; i--) begin
            r = fmul(r, r);
            if (e[i]) r = fmul(r, a);
        end
        return r;
    endfunction
    function automatic logic [511:0] add_g(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] s, rx, ry;
        s  = fmul(fsub(y, GY), finv(fsub(x, GX)));
        rx = fsub(fsub(fmul(s, s), x), GX);
        ry = fsub(fmul(s, fsub(x, rx)), y);
        return {rx, ry};
    endfunction

    // Adder model: random latency after reset release, level done held until reset.
    logic         a_done = 1'b0;
    logic [511:0] a_res  = '0;
    int           a_cnt  = 0;
    int           a_lat  = 1;
    always @(negedge clk) begin
        if (bus.adder_reset) begin
            a_done = 1'b0;
            a_cnt  = 0;
            a_lat  = $urandom_range(1, 4);
        end else if (!a_done) begin
            a_cnt++;
            if (a_cnt >= a_lat) begin
                a_res  = add_g(bus.adder_x, bus.adder_y);
                a_done = 1'b1;
            end
        end
    end
    assign bus.adder_done  = a_done;
    assign bus.adder_res_x = a_res[511:256];
    assign bus.adder_res_y = a_res[255:0];

    // Reference: k-th expected output is start + k*G.
    logic [255:0]     ex_x[$], ex_y[$];
    logic [255:0]     rx_x[$], rx_y[$];
    logic [CNT_W-1:0] rx_idx[$];
    logic             rx_last[$];
    int               hold_err;
    bit               timed_out;

    task automatic build_expected(input logic [255:0] x, input logic [255:0] y, input int n);
        logic [511:0] pt;
        ex_x.delete();
        ex_y.delete();
        pt = {x, y};
        for (int k = 1; k <= n; k++) begin
            pt = add_g(pt[511:256], pt[255:0]);
            ex_x.push_back(pt[511:256]);
            ex_y.push_back(pt[255:0]);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [255:0] x, input logic [255:0] y, input int n);
        bus.start_valid = 1'b1;
        bus.start_x     = x;
        bus.start_y     = y;
        bus.start_count = CNT_W'(n);
        cycle();
        bus.start_valid = 1'b0;
    endtask

    // Consumer: random out_ready, records accepted heads, notes head changes while stalled.
    task automatic collect(input int ready_pct);
        logic [255:0]     px, py;
        logic [CNT_W-1:0] pidx;
        logic             plast;
        bit               prev_stall;
        rx_x.delete(); rx_y.delete(); rx_idx.delete(); rx_last.delete();
        hold_err = 0; timed_out = 1'b1; prev_stall = 1'b0;
        px = '0; py = '0; pidx = '0; plast = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_stall && (!bus.out_valid || bus.out_x !== px || bus.out_y !== py ||
                               bus.out_idx !== pidx || bus.out_last !== plast))
                hold_err++;
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            if (bus.out_valid && bus.out_ready) begin
                rx_x.push_back(bus.out_x); rx_y.push_back(bus.out_y);
                rx_idx.push_back(bus.out_idx); rx_last.push_back(bus.out_last);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            px = bus.out_x; py = bus.out_y; pidx = bus.out_idx; plast = bus.out_last;
            cycle();
            if (!bus.busy && !bus.out_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        total++; if (bus.start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready got=%0b exp=1", bus.start_ready); end
        total++; if (bus.adder_reset !== 1'b1) begin bad++; $display("FAIL reset_adder_reset got=%0b exp=1", bus.adder_reset); end
        total++; if (bus.adder_x !== '0 || bus.adder_y !== '0) begin bad++; $display("FAIL reset_adder_xy got=%h exp=0", bus.adder_x); end
        total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy got=%0b%0b exp=00", bus.out_valid, bus.busy); end
        total++; if (bus.out_x !== '0 || bus.out_y !== '0 || bus.out_idx !== '0 || bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_fields idx=%0d last=%0b exp=0", bus.out_idx, bus.out_last); end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        do_start(G2X, G2Y, 1);
        collect(100);
        total++; if (timed_out) begin bad++; $display("FAIL single_timeout got=timeout exp=idle"); end
        total++; if (rx_x.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", rx_x.size()); end
        else begin
            total++; if (rx_idx[0] !== 1 || rx_last[0] !== 1'b1) begin bad++; $display("FAIL single_idx_last got=%0d/%0b exp=1/1", rx_idx[0], rx_last[0]); end
            total++; if (rx_x[0] !== G3X || rx_y[0] !== G3Y) begin bad++; $display("FAIL single_point got=%h exp=%h", rx_x[0], G3X); end
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_two_timing();
        int c;
        bus.out_ready = 1'b0;
        do_start(G2X, G2Y, 2);
        total++; if (bus.adder_reset !== 1'b0 || bus.adder_x !== G2X) begin bad++; $display("FAIL launch_operand got=%0b/%h exp=0/%h", bus.adder_reset, bus.adder_x, G2X); end
        for (c = 0; c < 20; c++) begin
            if (bus.adder_done && !bus.adder_reset) break;
            cycle();
        end
        total++; if (c == 20) begin bad++; $display("FAIL done_wait got=timeout exp=done"); end
        cycle();
        total++; if (bus.out_valid !== 1'b1 || bus.adder_reset !== 1'b1 || bus.out_idx !== 1) begin bad++; $display("FAIL done_plus1 got=v%0b r%0b i%0d exp=v1 r1 i1", bus.out_valid, bus.adder_reset, bus.out_idx); end
        cycle();
        total++; if (bus.adder_reset !== 1'b0) begin bad++; $display("FAIL done_plus2 got=%0b exp=0", bus.adder_reset); end
        collect(100);
        total++; if (timed_out || rx_x.size() != 2) begin bad++; $display("FAIL two_count got=%0d exp=2", rx_x.size()); end
        else begin
            total++; if (rx_idx[0] !== 1 || rx_last[0] !== 1'b0 || rx_x[0] !== G3X) begin bad++; $display("FAIL two_first got=%0d/%0b/%h exp=1/0/%h", rx_idx[0], rx_last[0], rx_x[0], G3X); end
            total++; if (rx_idx[1] !== 2 || rx_last[1] !== 1'b1 || rx_x[1] !== G4X) begin bad++; $display("FAIL two_second got=%0d/%0b/%h exp=2/1/%h", rx_idx[1], rx_last[1], rx_x[1], G4X); end
        end
    endtask

    task automatic test_stall();
        int dones, runs;
        dones = 0; runs = 0;
        bus.out_ready = 1'b0;
        build_expected(G2X, G2Y, 5);
        do_start(G2X, G2Y, 5);
        for (int c = 0; c < 40; c++) begin
            if (bus.adder_done && !bus.adder_reset) dones++;
            if (c >= 20 && !bus.adder_reset) runs++;
            cycle();
        end
        total++; if (dones != DEPTH) begin bad++; $display("FAIL stall_results got=%0d exp=%0d", dones, DEPTH); end
        total++; if (runs != 0 || bus.adder_reset !== 1'b1) begin bad++; $display("FAIL stall_adder_reset got=%0d low cycles exp=0", runs); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 1 || bus.out_x !== G3X) begin bad++; $display("FAIL stall_head got=v%0b i%0d exp=v1 i1", bus.out_valid, bus.out_idx); end
        collect(100);
        total++; if (timed_out || rx_x.size() != 5) begin bad++; $display("FAIL stall_count got=%0d exp=5", rx_x.size()); end
        for (int k = 0; k < rx_x.size() && k < 5; k++) begin
            total++;
            if (rx_idx[k] !== CNT_W'(k + 1) || rx_last[k] !== (k == 4) || rx_x[k] !== ex_x[k] || rx_y[k] !== ex_y[k]) begin
                bad++; $display("FAIL stall_item%0d got=%0d/%0b/%h exp=%0d/%0b/%h", k, rx_idx[k], rx_last[k], rx_x[k], k + 1, k == 4, ex_x[k]);
            end
        end
    endtask

    task automatic test_zero_count();
        int vhi, rlo;
        vhi = 0; rlo = 0;
        bus.out_ready = 1'b1;
        do_start(G2X, G2Y, 0);
        total++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL zero_ready got=%0b/%0b exp=1/0", bus.start_ready, bus.busy); end
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) vhi++;
            if (!bus.adder_reset) rlo++;
            cycle();
        end
        total++; if (vhi != 0 || rlo != 0) begin bad++; $display("FAIL zero_activity got=%0d valid %0d run exp=0 0", vhi, rlo); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        int c;
        bus.out_ready = 1'b0;
        do_start(G2X, G2Y, 5);
        for (c = 0; c < 40; c++) begin
            if (bus.out_valid && !bus.adder_reset) break;
            cycle();
        end
        total++; if (c == 40) begin bad++; $display("FAIL midreset_wait got=timeout exp=wait"); end
        reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1 || bus.adder_reset !== 1'b1) begin bad++; $display("FAIL midreset_ctrl got=b%0b s%0b r%0b exp=b0 s1 r1", bus.busy, bus.start_ready, bus.adder_reset); end
        total++; if (bus.out_valid !== 1'b0 || bus.out_x !== '0 || bus.out_idx !== '0 || bus.adder_x !== '0) begin bad++; $display("FAIL midreset_data got=v%0b i%0d exp=v0 i0", bus.out_valid, bus.out_idx); end
        cycle();
        reset = 1'b0;
        cycle();
        do_start(G2X, G2Y, 1);
        collect(100);
        total++; if (timed_out || rx_x.size() != 1) begin bad++; $display("FAIL midreset_restart_count got=%0d exp=1", rx_x.size()); end
        else begin
            total++; if (rx_x[0] !== G3X || rx_y[0] !== G3Y || rx_idx[0] !== 1) begin bad++; $display("FAIL midreset_restart got=%h exp=%h", rx_x[0], G3X); end
        end
    endtask

    task automatic test_random_walks();
        logic [255:0] sx, sy;
        int n, pct;
        for (int w = 0; w < 6; w++) begin
            sx = '0; sy = '0;
            for (int j = 0; j < 8; j++) begin
                sx = {sx[223:0], 32'($urandom)};
                sy = {sy[223:0], 32'($urandom)};
            end
            if (sx >= P) sx = sx - P;
            if (sy >= P) sy = sy - P;
            n   = $urandom_range(1, 6);
            pct = $urandom_range(20, 100);
            build_expected(sx, sy, n);
            do_start(sx, sy, n);
            collect(pct);
            total++; if (timed_out || rx_x.size() != n) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", w, rx_x.size(), n); end
            total++; if (hold_err != 0) begin bad++; $display("FAIL rand%0d_hold got=%0d exp=0", w, hold_err); end
            for (int k = 0; k < rx_x.size() && k < n; k++) begin
                total++;
                if (rx_idx[k] !== CNT_W'(k + 1) || rx_last[k] !== (k == n - 1) || rx_x[k] !== ex_x[k] || rx_y[k] !== ex_y[k]) begin
                    bad++; $display("FAIL rand%0d_item%0d got=%0d/%0b/%h exp=%0d/%0b/%h", w, k, rx_idx[k], rx_last[k], rx_x[k], k + 1, k == n - 1, ex_x[k]);
                end
            end
        end
    endtask

`ifdef PUBKEY_WALK_ABORT_EN
    task automatic test_abort();
        int c, dones;
        dones = 0;
        bus.out_ready = 1'b0;
        do_start(G2X, G2Y, 4);
        for (c = 0; c < 40; c++) begin
            if (bus.adder_done && !bus.adder_reset && bus.out_valid) break;
            cycle();
        end
        total++; if (c == 40) begin bad++; $display("FAIL abort_wait got=timeout exp=done"); end
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.adder_reset !== 1'b1) begin bad++; $display("FAIL abort_state got=b%0b v%0b r%0b exp=b0 v0 r1", bus.busy, bus.out_valid, bus.adder_reset); end
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid) dones++;
            cycle();
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", dones); end
        bus.abort = 1'b1;
        do_start(G2X, G2Y, 1);
        bus.abort = 1'b0;
        collect(100);
        total++; if (timed_out || rx_x.size() != 1 || rx_x[0] !== G3X) begin bad++; $display("FAIL abort_idle_ignored got=%0d items exp=1", rx_x.size()); end
    endtask
`endif

    initial begin
        reset           = 1'b1;
        bus.start_valid = 1'b0;
        bus.start_x     = '0;
        bus.start_y     = '0;
        bus.start_count = '0;
        bus.out_ready   = 1'b0;
`ifdef PUBKEY_WALK_ABORT_EN
        bus.abort       = 1'b0;
`endif
        test_reset();
        test_single();
        test_two_timing();
        test_stall();
        test_zero_count();
        test_reset_mid_walk();
        test_random_walks();
`ifdef PUBKEY_WALK_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
